// File: rtl/keccak_pkg.sv
// Shared Keccak constants: standard rates, domain separators and the padder FSM encoding.
package keccak_pkg;

    localparam int RATE_SHAKE128 = 168;
    localparam int RATE_SHAKE256 = 136;
    localparam int RATE_SHA3_256 = 136;
    localparam int RATE_SHA3_512 = 72;

    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] DS_SHA3  = 8'h06;

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_PAD       = 2'd1,
        ST_EMIT      = 2'd2,
        ST_EMIT_LAST = 2'd3
    } state_t;

endpackage

// File: rtl/keccak_padder.sv
// Byte-serial Keccak rate-block assembler with pad10*1 padding and domain separation.
// Emits full rate blocks with a valid/ready handshake; the final padded block is flagged block_last.
module keccak_padder
    import keccak_pkg::*;
#(
    parameter int RATE_BYTES = RATE_SHAKE256,
    parameter int DS_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_keep,
    input  logic                    in_last,
    input  logic [DS_WIDTH-1:0]     domain_sep,
    output logic                    in_ready,
    output logic [RATE_BYTES*8-1:0] block_out,
    output logic                    block_valid,
    input  logic                    block_ready,
    output logic                    block_last,
    output logic                    error_flag,
    output logic [1:0]              debug_state,
    output logic [7:0]              debug_byte_cnt
);

    localparam logic [7:0] LAST_CNT = 8'(RATE_BYTES - 1);
    localparam int         LAST_BIT = (RATE_BYTES - 1) * 8;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              byte_cnt;
    logic [7:0]              byte_cnt_next;
    logic [RATE_BYTES*8-1:0] buffer;
    logic [RATE_BYTES*8-1:0] buffer_next;
    logic                    pad_pending;
    logic                    pad_pending_next;
    logic [DS_WIDTH-1:0]     ds_latched;
    logic [DS_WIDTH-1:0]     ds_latched_next;
    logic                    error_next;
    logic [10:0]             bit_idx;
    logic [7:0]              ds_byte;

    assign in_ready       = (state == ST_FILL);
    assign block_out      = buffer;
    assign debug_state    = state;
    assign debug_byte_cnt = byte_cnt;
    assign bit_idx        = {byte_cnt, 3'b000};
    assign ds_byte        = 8'(ds_latched);

    // Next-state, buffer write/pad and handshake decisions.
    always_comb begin
        state_next       = state;
        byte_cnt_next    = byte_cnt;
        buffer_next      = buffer;
        pad_pending_next = pad_pending;
        ds_latched_next  = ds_latched;
        error_next       = error_flag;
        case (state)
            ST_FILL: begin
                if (in_valid) begin
                    if (in_keep) begin
                        buffer_next[bit_idx +: 8] = in_data;
                        byte_cnt_next = byte_cnt + 8'd1;
                        if (byte_cnt == LAST_CNT) begin
                            // A last byte that fills the block defers padding to a fresh block.
                            state_next = ST_EMIT;
                            if (in_last) begin
                                ds_latched_next  = domain_sep;
                                pad_pending_next = 1'b1;
                            end else begin
                                pad_pending_next = pad_pending;
                            end
                        end else if (in_last) begin
                            ds_latched_next = domain_sep;
                            state_next      = ST_PAD;
                        end else begin
                            state_next = ST_FILL;
                        end
                    end else if (in_last) begin
                        ds_latched_next = domain_sep;
                        state_next      = ST_PAD;
                    end else begin
                        error_next = 1'b1;
                    end
                end else begin
                    state_next = ST_FILL;
                end
            end
            ST_PAD: begin
                // Sequential XORs so coincident positions combine to ds ^ 0x80.
                buffer_next[bit_idx +: 8]  = buffer[bit_idx +: 8] ^ ds_byte;
                buffer_next[LAST_BIT +: 8] = buffer_next[LAST_BIT +: 8] ^ 8'h80;
                state_next                 = ST_EMIT_LAST;
            end
            ST_EMIT: begin
                if (block_ready) begin
                    buffer_next   = '0;
                    byte_cnt_next = 8'd0;
                    if (pad_pending) begin
                        pad_pending_next = 1'b0;
                        state_next       = ST_PAD;
                    end else begin
                        state_next = ST_FILL;
                    end
                end else begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT_LAST: begin
                if (block_ready) begin
                    buffer_next   = '0;
                    byte_cnt_next = 8'd0;
                    state_next    = ST_FILL;
                end else begin
                    state_next = ST_EMIT_LAST;
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // State, buffer and registered block handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FILL;
            byte_cnt    <= 8'd0;
            buffer      <= '0;
            pad_pending <= 1'b0;
            ds_latched  <= '0;
            error_flag  <= 1'b0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
        end else begin
            state       <= state_next;
            byte_cnt    <= byte_cnt_next;
            buffer      <= buffer_next;
            pad_pending <= pad_pending_next;
            ds_latched  <= ds_latched_next;
            error_flag  <= error_next;
            block_valid <= (state_next == ST_EMIT) || (state_next == ST_EMIT_LAST);
            block_last  <= (state_next == ST_EMIT_LAST);
        end
    end

endmodule
